// File: rtl/cmd_dispatcher_pkg.sv
// ============================================================================
// Module      : cmd_dispatcher_pkg
// Description : Shared definitions for the timed command dispatcher:
//               command-word field positions, FSM state encoding, the
//               default local address and the local timer-reset register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_dispatcher_pkg;

    // Command word layout: {timestamp, target addr, register, data}
    localparam int c_ts_msb   = 63;
    localparam int c_ts_lsb   = 32;
    localparam int c_addr_msb = 31;
    localparam int c_addr_lsb = 24;
    localparam int c_reg_msb  = 23;
    localparam int c_reg_lsb  = 16;
    localparam int c_data_msb = 15;
    localparam int c_data_lsb = 0;

    // Address serviced internally, and the register that clears cur_time
    localparam logic [7:0] c_local_addr_default = 8'hFF;
    localparam logic [7:0] c_reg_timer_reset    = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POP       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_TIME = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_WAIT_ACK  = 3'd5
    } state_t;

    function automatic logic [31:0] cmd_ts(input logic [63:0] w);
        return w[c_ts_msb:c_ts_lsb];
    endfunction

    function automatic logic [7:0] cmd_addr(input logic [63:0] w);
        return w[c_addr_msb:c_addr_lsb];
    endfunction

    function automatic logic [7:0] cmd_reg(input logic [63:0] w);
        return w[c_reg_msb:c_reg_lsb];
    endfunction

    function automatic logic [15:0] cmd_data(input logic [63:0] w);
        return w[c_data_msb:c_data_lsb];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_time_cmp.sv
// ============================================================================
// Module      : cmd_time_cmp
// Description : Wrap-safe 32-bit "is due" comparator. A timestamp is due
//               when it equals the current time or lies up to 2^31 cycles
//               in the past (sign bit of the modular difference set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_time_cmp (
    input  logic [31:0] i_timestamp,
    input  logic [31:0] i_cur_time,
    output logic        o_due
);

    logic [31:0] w_diff;

    // Modular difference; sign bit means the timestamp is already behind us
    always_comb begin
        w_diff = i_timestamp - i_cur_time;
        o_due  = w_diff[31] | (w_diff == 32'd0);
    end

endmodule

`default_nettype wire

// File: rtl/cmd_dispatcher.sv
// ============================================================================
// Module      : cmd_dispatcher
// Description : Pops timestamped commands from a FIFO, waits until each is
//               due against a free-running timer, then either services it
//               locally (LOCAL_ADDR, reg 0 clears the timer) or issues a
//               write on the register bus and waits for the acknowledge.
//               Optional bus-ack timeout: define CMD_DISPATCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_dispatcher
    import cmd_dispatcher_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 256,
    parameter logic [7:0] LOCAL_ADDR     = c_local_addr_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cmd_fifo_data_out,
    input  logic        cmd_fifo_empty,
    output logic        cmd_fifo_rd_en,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_reg,
    output logic [15:0] bus_data,
    output logic        bus_wr,
    input  logic        bus_ack,
    output logic [31:0] cur_time,
    output logic        busy,
    output logic        err_timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cmd_dispatcher: TIMEOUT_CYCLES out of range 2..65535");
    end

    state_t      state_q, state_d;
    logic [63:0] hold_q, hold_d;
    logic [31:0] cur_time_q, cur_time_d;
    logic        rd_en_q, rd_en_d;
    logic [7:0]  bus_addr_q, bus_addr_d;
    logic [7:0]  bus_reg_q, bus_reg_d;
    logic [15:0] bus_data_q, bus_data_d;
    logic        bus_wr_q, bus_wr_d;
    logic        busy_q, busy_d;
    logic        w_due;

`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    cmd_time_cmp u_time_cmp (
        .i_timestamp (cmd_ts(hold_q)),
        .i_cur_time  (cur_time_q),
        .o_due       (w_due)
    );

    // Next-state and next-output logic for the dispatch FSM and timer
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cur_time_d = cur_time_q + 32'd1;
        rd_en_d    = 1'b0;
        bus_addr_d = bus_addr_q;
        bus_reg_d  = bus_reg_q;
        bus_data_d = bus_data_q;
        bus_wr_d   = bus_wr_q;
`ifdef CMD_DISPATCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!cmd_fifo_empty) begin
                    state_d = ST_POP;
                    rd_en_d = 1'b1;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // FIFO head is valid the cycle after the pop strobe
                hold_d  = cmd_fifo_data_out;
                state_d = ST_WAIT_TIME;
            end
            ST_WAIT_TIME: begin
                if (w_due) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
                if (cmd_addr(hold_q) == LOCAL_ADDR) begin
                    // Local commands never reach the bus; only reg 0 acts
                    if (cmd_reg(hold_q) == c_reg_timer_reset) begin
                        cur_time_d = 32'd0;
                    end
                end else begin
                    bus_addr_d = cmd_addr(hold_q);
                    bus_reg_d  = cmd_reg(hold_q);
                    bus_data_d = cmd_data(hold_q);
                    bus_wr_d   = 1'b1;
                    state_d    = ST_WAIT_ACK;
                end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                cnt_d = 16'd0;
`endif
            end
            ST_WAIT_ACK: begin
                // An ack in the final timeout cycle still wins
                if (bus_ack) begin
                    bus_wr_d = 1'b0;
                    state_d  = ST_IDLE;
                end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                else if (cnt_q == c_timeout_last) begin
                    bus_wr_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                bus_wr_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset discards any held command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= 64'd0;
            cur_time_q <= 32'd0;
            rd_en_q    <= 1'b0;
            bus_addr_q <= 8'd0;
            bus_reg_q  <= 8'd0;
            bus_data_q <= 16'd0;
            bus_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            cnt_q      <= 16'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cur_time_q <= cur_time_d;
            rd_en_q    <= rd_en_d;
            bus_addr_q <= bus_addr_d;
            bus_reg_q  <= bus_reg_d;
            bus_data_q <= bus_data_d;
            bus_wr_q   <= bus_wr_d;
            busy_q     <= busy_d;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign cmd_fifo_rd_en = rd_en_q;
    assign bus_addr       = bus_addr_q;
    assign bus_reg        = bus_reg_q;
    assign bus_data       = bus_data_q;
    assign bus_wr         = bus_wr_q;
    assign cur_time       = cur_time_q;
    assign busy           = busy_q;
`ifdef CMD_DISPATCH_TIMEOUT_EN
    assign err_timeout    = err_q;
`else
    assign err_timeout    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmd_dispatcher.sv
// ============================================================================
// Module      : tb_cmd_dispatcher
// Description : Directed self-checking bench for cmd_dispatcher with a
//               behavioural command FIFO and a bus-ack responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_dispatcher;

`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam int c_tmo = 16;
`else
    localparam int c_tmo = 256;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cmd_fifo_data_out;
    logic        cmd_fifo_empty;
    logic        cmd_fifo_rd_en;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_reg;
    logic [15:0] bus_data;
    logic        bus_wr;
    logic        bus_ack;
    logic [31:0] cur_time;
    logic        busy;
    logic        err_timeout;

    logic [31:0] cmp_ts;
    logic [31:0] cmp_cur;
    logic        cmp_due;

    logic [63:0] fifo_q[$];
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          rd_cnt  = 0;
    int          push_cnt = 0;

    always #5 clk = ~clk;

    cmd_dispatcher #(
        .TIMEOUT_CYCLES (c_tmo),
        .LOCAL_ADDR     (8'hFF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_fifo_data_out (cmd_fifo_data_out),
        .cmd_fifo_empty    (cmd_fifo_empty),
        .cmd_fifo_rd_en    (cmd_fifo_rd_en),
        .bus_addr          (bus_addr),
        .bus_reg           (bus_reg),
        .bus_data          (bus_data),
        .bus_wr            (bus_wr),
        .bus_ack           (bus_ack),
        .cur_time          (cur_time),
        .busy              (busy),
        .err_timeout       (err_timeout)
    );

    cmd_time_cmp u_cmp (
        .i_timestamp (cmp_ts),
        .i_cur_time  (cmp_cur),
        .o_due       (cmp_due)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [31:0] ts, input logic [7:0] a,
                                       input logic [7:0] r, input logic [15:0] d);
        return {ts, a, r, d};
    endfunction

    task automatic push(input logic [63:0] w);
        fifo_q.push_back(w);
        push_cnt++;
        cmd_fifo_empty = 1'b0;
    endtask

    // One clock; FIFO pops on the edge where rd_en was high, sample at #1
    task automatic step();
        logic pop;
        pop = cmd_fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) cmd_fifo_data_out = fifo_q.pop_front();
        cmd_fifo_empty = (fifo_q.size() == 0);
        if (cmd_fifo_rd_en === 1'b1) begin
            rd_cnt++;
            check_eq("rd_en_while_empty", cmd_fifo_empty, 1'b0);
        end
    endtask

    // Wait for bus_wr; optionally drive stray acks that must be ignored
    task automatic wait_wr(input int budget, input logic noise);
        int n;
        n = 0;
        while (bus_wr !== 1'b1 && n < budget) begin
            bus_ack = noise;
            step();
            n++;
        end
        bus_ack = 1'b0;
        check_eq("wr_seen", bus_wr, 1'b1);
    endtask

    // Hold ack off until the ack_at-th cycle of bus_wr (0 = never)
    task automatic run_bus(input int ack_at, input int budget, output int hi);
        logic [31:0] fields;
        fields = {bus_addr, bus_reg, bus_data};
        hi = 0;
        while (bus_wr === 1'b1 && hi < budget) begin
            hi++;
            check_eq("bus_stable", {bus_addr, bus_reg, bus_data}, fields);
            bus_ack = (hi == ack_at);
            step();
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        int          hi;
        logic        wr_any;
        logic [31:0] t0;
        logic [63:0] cmp_vec [5];
        logic        cmp_exp [5];

        rst = 1'b1;
        bus_ack = 1'b0;
        cmd_fifo_empty = 1'b1;
        cmd_fifo_data_out = 64'd0;
        repeat (3) step();

        check_eq("rst_rd_en", cmd_fifo_rd_en, 1'b0);
        check_eq("rst_bus_wr", bus_wr, 1'b0);
        check_eq("rst_fields", {bus_addr, bus_reg, bus_data}, 32'd0);
        check_eq("rst_cur_time", cur_time, 32'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err_timeout, 1'b0);
        rst = 1'b0;
        step();
        check_eq("cur_time_inc", cur_time, 32'd1);

        // Immediate command, ack in the 3rd bus_wr cycle
        push(mk(32'd0, 8'h03, 8'h10, 16'hBEEF));
        step();
        check_eq("busy_pop", busy, 1'b1);
        wait_wr(20, 1'b0);
        check_eq("t0_fields", {bus_addr, bus_reg, bus_data}, 32'h0310BEEF);
        run_bus(3, 20, hi);
        check_eq("t0_wr_len", hi, 3);
        check_eq("t0_idle", busy, 1'b0);

        // Timestamp 1000 loaded at cur_time 10: due at 1000, ISSUE at 1001,
        // so bus_wr is first visible in the cycle with cur_time 1002
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20 && cur_time != 32'd8; i++) step();
        push(mk(32'd1000, 8'h21, 8'h07, 16'h1234));
        wait_wr(1100, 1'b1);
        check_eq("t1000_wr_time", cur_time, 32'd1002);
        check_eq("t1000_fields", {bus_addr, bus_reg, bus_data}, 32'h21071234);
        run_bus(2, 20, hi);
        check_eq("t1000_wr_len", hi, 2);

        // Wrap-safe comparator at 32-bit rollover, timestamp 0x10
        cmp_vec[0] = {32'h10, 32'hFFFFFFF0}; cmp_exp[0] = 1'b0;
        cmp_vec[1] = {32'h10, 32'hFFFFFFFF}; cmp_exp[1] = 1'b0;
        cmp_vec[2] = {32'h10, 32'h0000000F}; cmp_exp[2] = 1'b0;
        cmp_vec[3] = {32'h10, 32'h00000010}; cmp_exp[3] = 1'b1;
        cmp_vec[4] = {32'h10, 32'h00000011}; cmp_exp[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmp_ts  = cmp_vec[i][63:32];
            cmp_cur = cmp_vec[i][31:0];
            #1;
            check_eq($sformatf("wrap_cmp_%0d", i), cmp_due, cmp_exp[i]);
        end

        // Local timer reset: ISSUE lands on cur_time 5000
        for (int i = 0; i < 5000 && cur_time != 32'd4996; i++) step();
        push(mk(32'd0, 8'hFF, 8'h00, 16'h0000));
        wr_any = 1'b0;
        repeat (4) begin
            step();
            wr_any |= bus_wr;
        end
        check_eq("lreset_at_5000", cur_time, 32'd5000);
        check_eq("lreset_busy", busy, 1'b1);
        step();
        check_eq("lreset_cur_time", cur_time, 32'd0);
        repeat (3) begin
            wr_any |= bus_wr;
            step();
        end
        check_eq("lreset_no_wr", wr_any, 1'b0);

        // Local address, other register: discarded, timer untouched
        t0 = cur_time;
        push(mk(32'd0, 8'hFF, 8'h05, 16'h1234));
        wr_any = 1'b0;
        repeat (8) begin
            step();
            wr_any |= bus_wr;
        end
        check_eq("ldiscard_no_wr", wr_any, 1'b0);
        check_eq("ldiscard_time", cur_time, t0 + 32'd8);
        check_eq("ldiscard_idle", busy, 1'b0);

        // Back-to-back: rise-to-rise spacing with a 1-cycle ack is 6
        push(mk(32'd0, 8'h11, 8'h22, 16'h3333));
        push(mk(32'd0, 8'h44, 8'h55, 16'h6666));
        wait_wr(20, 1'b0);
        check_eq("b2b_a_fields", {bus_addr, bus_reg, bus_data}, 32'h11223333);
        t0 = cur_time;
        run_bus(1, 20, hi);
        wait_wr(20, 1'b0);
        check_eq("b2b_b_fields", {bus_addr, bus_reg, bus_data}, 32'h44556666);
        check_eq("b2b_spacing", cur_time - t0, 32'd6);
        run_bus(1, 20, hi);

`ifdef CMD_DISPATCH_TIMEOUT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        push(mk(32'd0, 8'h31, 8'h01, 16'hA001));
        wait_wr(20, 1'b0);
        run_bus(16, 40, hi);
        check_eq("tmo_ack16_len", hi, 16);
        check_eq("tmo_ack16_err", err_timeout, 1'b0);
        push(mk(32'd0, 8'h32, 8'h02, 16'hA002));
        wait_wr(20, 1'b0);
        run_bus(0, 40, hi);
        check_eq("tmo_noack_len", hi, 16);
        check_eq("tmo_noack_err", err_timeout, 1'b1);
        push(mk(32'd0, 8'h33, 8'h03, 16'hA003));
        wait_wr(20, 1'b0);
        check_eq("tmo_next_fields", {bus_addr, bus_reg, bus_data}, 32'h3303A003);
        run_bus(1, 20, hi);
        check_eq("tmo_sticky", err_timeout, 1'b1);
`else
        push(mk(32'd0, 8'h31, 8'h01, 16'hA001));
        wait_wr(20, 1'b0);
        run_bus(0, 300, hi);
        check_eq("noto_still_wr", bus_wr, 1'b1);
        check_eq("noto_err", err_timeout, 1'b0);
        run_bus(1, 20, hi);
        check_eq("noto_ack_len", hi, 1);
        check_eq("noto_idle", busy, 1'b0);
`endif

        // Reset during WAIT_ACK, then two queued commands issue in order
        push(mk(32'd0, 8'h0A, 8'h0A, 16'h0A0A));
        wait_wr(20, 1'b0);
        push(mk(32'd0, 8'h0B, 8'h0B, 16'h0B0B));
        push(mk(32'd0, 8'h0C, 8'h0C, 16'h0C0C));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_wr", bus_wr, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_fields", {bus_addr, bus_reg, bus_data}, 32'd0);
        check_eq("mid_rst_err", err_timeout, 1'b0);
        wait_wr(20, 1'b0);
        check_eq("mid_rst_b", {bus_addr, bus_reg, bus_data}, 32'h0B0B0B0B);
        run_bus(1, 20, hi);
        wait_wr(20, 1'b0);
        check_eq("mid_rst_c", {bus_addr, bus_reg, bus_data}, 32'h0C0C0C0C);
        run_bus(1, 20, hi);
        repeat (3) step();
        check_eq("rd_en_pulses", rd_cnt, push_cnt);
        check_eq("fifo_drained", cmd_fifo_empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
